rr_arb4: RTL and testbench



---
 rtl/rr_arb4.sv | 154 +++++++++++++++
 tb/tb_rr_arb4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rr_arb4 - round-robin arbiter and sequencer for the 4:1 one-bit mux.
//
// Four requesters compete for one mux output path. One owner is granted at a
// time, for at most MAX_HOLD consecutive cycles, and then arbitration runs
// again. The owner's mux select lines are driven, and its data bit is
// registered onto y.
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles one grant may be held (1..15)
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   req   in   [3:0] request lines, req[i] <-> mux input a/b/c/d
//   din   in   [3:0] data bits a..d
//   gnt   out  [3:0] one-hot grant, registered, zero when idle
//   s1    out  mux select s1 (= own[0]), registered, held while idle
//   s0    out  mux select s0 (= own[1]), registered, held while idle
//   y     out  din[own] registered one cycle after the granted cycle
//   busy  out  high while a grant is active
module rr_arb4 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       y,
  output logic       busy
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] own_reg, own_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] gnt_reg, gnt_next;
  logic       s1_reg, s1_next;
  logic       s0_reg, s0_next;
  logic       y_reg, y_next;
  logic       busy_reg, busy_next;

  // Arbitration helpers.
  logic [7:0] req_dbl;
  logic [3:0] req_rot;     // req rotated so that bit 0 is the ptr position
  logic [1:0] win_off;     // offset of the winner from ptr
  logic [1:0] win;         // absolute winner index
  logic       any_req;
  logic       release_now;
  logic [3:0] own_dec;     // one-hot decode of own_next

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_reg +: 4];
  assign any_req = |req;
  assign win     = ptr_reg + win_off;

  // First set bit of the rotated request vector; scanning downward lets the
  // lowest offset (highest priority) overwrite any later ones.
  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = k[1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      assign own_dec[gi] = (own_next == 2'(gi));
    end
  endgenerate

  // IDLE always arbitrates; GRANT arbitrates when the owner lets go or
  // reaches the hold limit.
  assign release_now = (state_reg == IDLE) || !req[own_reg] || (cnt_reg == HOLD_MAX);

  always_comb begin
    state_next = state_reg;
    own_next   = own_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;

    if (release_now) begin
      if (any_req) begin
        // ptr already sits past the previous owner, so that owner ranks
        // last and only wins again if nobody else is asking.
        state_next = GRANT;
        own_next   = win;
        cnt_next   = 4'd1;
        ptr_next   = win + 2'd1;
      end else begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    end else begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  always_comb begin
    gnt_next  = 4'b0000;
    busy_next = 1'b0;
    s1_next   = s1_reg;
    s0_next   = s0_reg;
    if (state_next == GRANT) begin
      gnt_next  = own_dec;
      busy_next = 1'b1;
      s1_next   = own_next[0];
      s0_next   = own_next[1];
    end
    // y carries the data of whoever owned the mux during the cycle just ending.
    y_next = (state_reg == GRANT) ? din[own_reg] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      own_reg   <= 2'd0;
      cnt_reg   <= 4'd0;
      ptr_reg   <= 2'd0;
      gnt_reg   <= 4'b0000;
      s1_reg    <= 1'b0;
      s0_reg    <= 1'b0;
      y_reg     <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      own_reg   <= own_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      s1_reg    <= s1_next;
      s0_reg    <= s0_next;
      y_reg     <= y_next;
      busy_reg  <= busy_next;
    end
  end

  assign gnt  = gnt_reg;
  assign s1   = s1_reg;
  assign s0   = s0_reg;
  assign y    = y_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_rr_arb4.sv
// Testbench for rr_arb4. Two instances (MAX_HOLD=4 and MAX_HOLD=2) share
// the same stimulus. A reference model predicts every cycle's outputs and
// pushes them into a queue per instance; a monitor pops and compares.
module tb_rr_arb4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;

  logic [3:0] gnt_a, gnt_b;
  logic       s1_a, s0_a, y_a, busy_a;
  logic       s1_b, s0_b, y_b, busy_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done     = 0;

  rr_arb4 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_a), .s1(s1_a), .s0(s0_a), .y(y_a), .busy(busy_a)
  );

  rr_arb4 #(.MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_b), .s1(s1_b), .s0(s0_b), .y(y_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       y;
    logic       busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state per instance: owner (-1 = nobody), cycles held,
  // round-robin start position, last select values.
  int m_own  [2] = '{-1, -1};
  int m_held [2] = '{0, 0};
  int m_ptr  [2] = '{0, 0};
  int m_lim  [2] = '{4, 2};
  bit m_s1   [2] = '{0, 0};
  bit m_s0   [2] = '{0, 0};

  function automatic exp_t model_step(int i, bit r, logic [3:0] rq, logic [3:0] d);
    exp_t e;
    bit   rel;
    int   pick;
    if (r) begin
      m_own[i]  = -1;
      m_held[i] = 0;
      m_ptr[i]  = 0;
      m_s1[i]   = 0;
      m_s0[i]   = 0;
      e.gnt = 4'b0000; e.s1 = 0; e.s0 = 0; e.y = 0; e.busy = 0;
      return e;
    end
    e.y = (m_own[i] >= 0) ? d[m_own[i]] : 1'b0;
    rel = (m_own[i] < 0) || !rq[m_own[i]] || (m_held[i] == m_lim[i]);
    if (!rel) begin
      m_held[i]++;
    end else begin
      pick = -1;
      for (int k = 0; k < 4; k++) begin
        if (pick < 0 && rq[(m_ptr[i] + k) % 4]) pick = (m_ptr[i] + k) % 4;
      end
      m_own[i] = pick;
      if (pick >= 0) begin
        m_held[i] = 1;
        m_ptr[i]  = (pick + 1) % 4;
      end else begin
        m_held[i] = 0;
      end
    end
    if (m_own[i] >= 0) begin
      e.gnt  = 4'(1 << m_own[i]);
      e.busy = 1;
      m_s1[i] = (m_own[i] % 2) == 1;
      m_s0[i] = (m_own[i] / 2) == 1;
    end else begin
      e.gnt  = 4'b0000;
      e.busy = 0;
    end
    e.s1 = m_s1[i];
    e.s0 = m_s0[i];
    return e;
  endfunction

  // Model: sample inputs at each active edge and queue the expected outputs.
  initial begin
    forever begin
      @(posedge clk);
      q_a.push_back(model_step(0, rst, req, din));
      q_b.push_back(model_step(1, rst, req, din));
    end
  end

  task automatic cmp(string name, int inst, logic [3:0] got, logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%b exp=%b", name, inst, cyc, got, want);
    end
  endtask

  task automatic check_inst(int inst, exp_t e, logic [3:0] g, logic a1, logic a0,
                            logic ay, logic ab);
    cmp("gnt", inst, g, e.gnt);
    cmp("s1", inst, {3'b0, a1}, {3'b0, e.s1});
    cmp("s0", inst, {3'b0, a0}, {3'b0, e.s0});
    cmp("y", inst, {3'b0, ay}, {3'b0, e.y});
    cmp("busy", inst, {3'b0, ab}, {3'b0, e.busy});
  endtask

  // Monitor: outputs are settled 1 time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        cyc++;
        if (q_a.size() == 0 || q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL queue_empty cyc=%0d got=0 exp=1", cyc);
        end else begin
          e = q_a.pop_front();
          check_inst(0, e, gnt_a, s1_a, s0_a, y_a, busy_a);
          e = q_b.pop_front();
          check_inst(1, e, gnt_b, s1_b, s0_b, y_b, busy_b);
        end
      end
    end
  end

  task automatic drive(bit r, logic [3:0] rq, logic [3:0] d, int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r;
      req = rq;
      din = d;
    end
  endtask

  initial begin
    logic [3:0] rq;
    // Reset with all requesting, then first grant goes to index 0.
    drive(1, 4'b1111, 4'b0000, 2);
    drive(0, 4'b1111, 4'b1010, 3);
    // Single requester on c with its data bit set.
    drive(1, 4'b0000, 4'b0000, 1);
    drive(0, 4'b0100, 4'b0100, 10);
    // Everyone requesting: rotation.
    drive(0, 4'b1111, 4'b0110, 12);
    // Early release: owner 1, then drop req[1] with req[3] waiting.
    drive(1, 4'b0000, 4'b0000, 1);
    drive(0, 4'b0010, 4'b1111, 1);
    drive(0, 4'b1010, 4'b1111, 1);
    drive(0, 4'b1000, 4'b1111, 2);
    // Idle hold after owner 3 drops.
    drive(0, 4'b0000, 4'b1111, 3);
    // Reset mid-grant, then fresh arbitration from ptr 0.
    drive(0, 4'b0100, 4'b0100, 2);
    drive(1, 4'b0100, 4'b0100, 1);
    drive(0, 4'b0110, 4'b0011, 4);
    // Random, bursty requests with occasional resets.
    rq = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 149) == 0), rq, 4'($urandom_range(0, 15)), 1);
    end
    drive(0, 4'b0000, 4'b0000, 3);
    @(posedge clk);
    #2;
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
